control_sequencer: RTL and testbench
====================================

# control_sequencer

Upstream control stage of the Harvard CPU. It owns the one-hot instruction-cycle state (fetch / exec1 / exec2) and the instruction register, and feeds the instruction decoder with `state[2:0]` and `inst[3:0]`. It latches each program-ROM word during fetch and selects a one- or two-execute-cycle sequence from the opcode. It also handles run / single-step / halt control and counts retired instructions.

## Interface
Parameters:
- `DATA_W`, 8: program-ROM word width; opcode is the top 4 bits, operand is the rest.
- `COUNT_W`, 8: width of the retired-instruction counter.

Ports:
- `clk`  in  1: single system clock; all state changes on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `run`  in  1: level; free-running execution while high.
- `step`  in  1: one-cycle pulse; executes exactly one instruction when sampled in IDLE with `run` low.
- `rom_data`  in  DATA_W: program-ROM output for the current PC; must be valid during FETCH.
- `state`  out  3: one-hot to decoder; bit0 FETCH, bit1 EXEC1, bit2 EXEC2; 000 in IDLE/HALT.
- `inst`  out  4: registered opcode = `rom_data[DATA_W-1:DATA_W-4]`.
- `operand`  out  DATA_W-4: registered operand = `rom_data[DATA_W-5:0]`.
- `halted`  out  1: high while in HALT.
- `retire`  out  1: high during the final execute cycle of every instruction.
- `instr_count`  out  COUNT_W: number of retired instructions.

## Operation
- Opcode classes (`inst`):
  - Two-exec: LDA=0101, ADD=0010.
  - Stop: STP=0100.
  - All others, including ARM (`inst[3]`=1), are one-exec.
- States: IDLE, FETCH, EXEC1, EXEC2, HALT. The FSM is internally encoded; `state` output is derived per the table in Interface.
- Transitions:
  - IDLE -> FETCH if `run`, or if `step` with `run` low; otherwise stay in IDLE.
  - FETCH -> EXEC1 always. On this edge: `inst` <= `rom_data[DATA_W-1:DATA_W-4]`, `operand` <= `rom_data[DATA_W-5:0]`.
  - EXEC1 -> HALT if `inst`=STP.
  - EXEC1 -> EXEC2 if `inst` is LDA or ADD.
  - EXEC1 otherwise -> next state per the end-of-instruction rule.
  - EXEC2 -> next state per the end-of-instruction rule.
  - HALT -> HALT until `rst`. `run` and `step` are ignored in HALT.
- End-of-instruction rule: go to FETCH if `run`=1 at the retiring edge, else go to IDLE.
- `run` deasserted mid-instruction: the current instruction completes, then the FSM enters IDLE.
- `step`: sampled only in IDLE with `run`=0. It is ignored in every other state and ignored while `run`=1.
- `retire` = (EXEC1 & inst is not LDA/ADD) | EXEC2. STP retires in its EXEC1.
- `instr_count`: increments on every edge where `retire`=1 and wraps modulo 2^COUNT_W with no saturation.
- `inst` and `operand` hold their values outside the FETCH->EXEC1 edge, including across IDLE and HALT.

## Timing
- Reset values: FSM IDLE, `state`=000, `inst`=0, `operand`=0, `halted`=0, `retire`=0, `instr_count`=0.
- `rst` asserted in any state, including mid-EXEC: the FSM is in IDLE at the next edge and no partial retire is counted. `rst` has priority over `run` and `step`.
- `state`, `halted` and `retire` are decoded from registered FSM state only. They are glitch-free relative to inputs and do not depend combinationally on `run`, `step` or `rom_data`.
- Latency:
  - `run` high in IDLE at edge N -> FETCH in cycle N+1, EXEC1 in N+2.
  - One-exec instruction: 2 cycles.
  - LDA/ADD: 3 cycles.
  - Back-to-back instructions have no bubble: the cycle after the last EXEC is FETCH.
- Decoder contract: `inst` is stable throughout EXEC1/EXEC2. `inst` is stale during FETCH, and the decoder gates on `state`.
- PC (external) advances at the end of EXEC1. `rom_data` for the next instruction is valid in the following FETCH.
- Simultaneous `run` rising and `step` in IDLE: treated as run. The step is not remembered.

## Test plan
- Reset: assert `rst` 2 cycles with random inputs -> all outputs at reset values, FSM IDLE.
- Free run, ROM 0x05 (LDI op 5), 0x27 (ADD op 7), 0x40 (STP):
  - `state` sequence 001,010,001,010,100,001,010,000.
  - `inst` = 0,2,4 in successive EXEC1 cycles; `operand`=5 then 7.
  - `halted`=1 after STP; `instr_count`=3.
- Single step, `run`=0, `step` pulse with ROM 0x53 (LDA) -> 001,010,100 then IDLE (000); `retire` high only in EXEC2; `instr_count`=1; further `step` pulses mid-instruction are ignored.
- Run drop: deassert `run` during EXEC1 of an ADD -> EXEC2 completes, then IDLE; `instr_count` +1.
- Reset mid-instruction: `rst` in EXEC2 of LDA -> IDLE next cycle, `instr_count` unchanged from pre-instruction value (0 if first), `halted`=0.
- Counter wrap, COUNT_W=8: run 256 one-exec ARM instructions (0x8x) -> `instr_count` wraps 255->0 on the 256th retire.

Source files
------------

// File: rtl/control_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | control_sequencer_if                                                 |
// | Run/step/ROM inputs and decoder-facing outputs of the sequencer.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface control_sequencer_if #(
    parameter int DATA_W  = 8,
    parameter int COUNT_W = 8
);
    logic               run;
    logic               step;
    logic [DATA_W-1:0]  rom_data;
    logic [2:0]         state;
    logic [3:0]         inst;
    logic [DATA_W-5:0]  operand;
    logic               halted;
    logic               retire;
    logic [COUNT_W-1:0] instr_count;

    modport master (
        output run, step, rom_data,
        input  state, inst, operand, halted, retire, instr_count
    );

    modport slave (
        input  run, step, rom_data,
        output state, inst, operand, halted, retire, instr_count
    );
endinterface
`default_nettype wire

// File: rtl/control_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | control_sequencer                                                    |
// | Fetch/exec1/exec2 instruction-cycle FSM with IR, run/step/halt       |
// | control and retired-instruction counter.                             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module control_sequencer #(
    parameter int DATA_W  = 8,
    parameter int COUNT_W = 8
) (
    input  wire logic          clk,
    input  wire logic          rst,
    control_sequencer_if.slave cs
);
    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_FETCH = 3'd1;
    localparam logic [2:0] c_EXEC1 = 3'd2;
    localparam logic [2:0] c_EXEC2 = 3'd3;
    localparam logic [2:0] c_HALT  = 3'd4;

    localparam logic [3:0] c_OP_ADD = 4'b0010;
    localparam logic [3:0] c_OP_STP = 4'b0100;
    localparam logic [3:0] c_OP_LDA = 4'b0101;

    localparam logic [COUNT_W-1:0] c_COUNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

    logic [2:0]         r_fsm;
    logic [3:0]         r_inst;
    logic [DATA_W-5:0]  r_operand;
    logic [2:0]         r_state_oh;
    logic               r_halted;
    logic               r_retire;
    logic [COUNT_W-1:0] r_count;

    logic [2:0]         w_next_fsm;
    logic [2:0]         w_end_fsm;
    logic [3:0]         w_next_inst;
    logic [DATA_W-5:0]  w_next_operand;
    logic               w_cur_two;
    logic               w_next_two;

    assign w_cur_two  = (r_inst == c_OP_LDA) || (r_inst == c_OP_ADD);
    assign w_next_two = (w_next_inst == c_OP_LDA) || (w_next_inst == c_OP_ADD);
    assign w_end_fsm  = cs.run ? c_FETCH : c_IDLE;

    always_comb begin
        w_next_fsm     = r_fsm;
        w_next_inst    = r_inst;
        w_next_operand = r_operand;
        case (r_fsm)
            c_IDLE:  if (cs.run || cs.step) w_next_fsm = c_FETCH;
            c_FETCH: begin
                w_next_fsm     = c_EXEC1;
                w_next_inst    = cs.rom_data[DATA_W-1:DATA_W-4];
                w_next_operand = cs.rom_data[DATA_W-5:0];
            end
            c_EXEC1: begin
                if (r_inst == c_OP_STP) w_next_fsm = c_HALT;
                else if (w_cur_two)     w_next_fsm = c_EXEC2;
                else                    w_next_fsm = w_end_fsm;
            end
            c_EXEC2: w_next_fsm = w_end_fsm;
            c_HALT:  w_next_fsm = c_HALT;
            default: w_next_fsm = c_IDLE;
        endcase
    end

    // Decoder-facing outputs are computed from the next state so they come
    // straight out of flops and never follow run/step/rom_data within a cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm      <= c_IDLE;
            r_inst     <= 4'd0;
            r_operand  <= '0;
            r_state_oh <= 3'b000;
            r_halted   <= 1'b0;
            r_retire   <= 1'b0;
            r_count    <= '0;
        end else begin
            r_fsm      <= w_next_fsm;
            r_inst     <= w_next_inst;
            r_operand  <= w_next_operand;
            r_state_oh <= {w_next_fsm == c_EXEC2, w_next_fsm == c_EXEC1,
                           w_next_fsm == c_FETCH};
            r_halted   <= (w_next_fsm == c_HALT);
            r_retire   <= ((w_next_fsm == c_EXEC1) && !w_next_two) ||
                          (w_next_fsm == c_EXEC2);
            if (r_retire) r_count <= r_count + c_COUNT_ONE;
        end
    end

    assign cs.state       = r_state_oh;
    assign cs.inst        = r_inst;
    assign cs.operand     = r_operand;
    assign cs.halted      = r_halted;
    assign cs.retire      = r_retire;
    assign cs.instr_count = r_count;
endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_control_sequencer                                                 |
// | Directed self-checking bench for control_sequencer.                  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_control_sequencer;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    control_sequencer_if #(.DATA_W(8), .COUNT_W(8)) bus ();

    control_sequencer #(.DATA_W(8), .COUNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .cs  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [2:0] st, input logic ha,
                             input logic re, input logic [7:0] cnt);
        check({tag, ".state"},  {29'd0, bus.state}, {29'd0, st});
        check({tag, ".halted"}, {31'd0, bus.halted}, {31'd0, ha});
        check({tag, ".retire"}, {31'd0, bus.retire}, {31'd0, re});
        check({tag, ".count"},  {24'd0, bus.instr_count}, {24'd0, cnt});
    endtask

    initial begin
        total = 0;
        bad   = 0;

        // Reset with random inputs
        rst          = 1'b1;
        bus.run      = 1'($urandom);
        bus.step     = 1'($urandom);
        bus.rom_data = 8'($urandom);
        tick();
        bus.rom_data = 8'($urandom);
        tick();
        check_all("reset", 3'b000, 1'b0, 1'b0, 8'd0);
        check("reset.inst", {28'd0, bus.inst}, 32'd0);
        check("reset.operand", {28'd0, bus.operand}, 32'd0);
        rst      = 1'b0;
        bus.run  = 1'b0;
        bus.step = 1'b0;
        tick();
        check_all("idle", 3'b000, 1'b0, 1'b0, 8'd0);

        // Free run: 0x05, 0x27 (ADD), 0x40 (STP)
        bus.rom_data = 8'h05;
        bus.run      = 1'b1;
        tick();
        check_all("run.f1", 3'b001, 1'b0, 1'b0, 8'd0);
        tick();
        check_all("run.e1a", 3'b010, 1'b0, 1'b1, 8'd0);
        check("run.inst0", {28'd0, bus.inst}, 32'd0);
        check("run.op0", {28'd0, bus.operand}, 32'd5);
        bus.rom_data = 8'h27;
        tick();
        check_all("run.f2", 3'b001, 1'b0, 1'b0, 8'd1);
        tick();
        check_all("run.e1b", 3'b010, 1'b0, 1'b0, 8'd1);
        check("run.inst2", {28'd0, bus.inst}, 32'd2);
        check("run.op7", {28'd0, bus.operand}, 32'd7);
        bus.rom_data = 8'h40;
        tick();
        check_all("run.e2b", 3'b100, 1'b0, 1'b1, 8'd1);
        tick();
        check_all("run.f3", 3'b001, 1'b0, 1'b0, 8'd2);
        check("run.stale_inst", {28'd0, bus.inst}, 32'd2);
        tick();
        check_all("run.e1c", 3'b010, 1'b0, 1'b1, 8'd2);
        check("run.inst4", {28'd0, bus.inst}, 32'd4);
        tick();
        check_all("run.halt", 3'b000, 1'b1, 1'b0, 8'd3);
        bus.step = 1'b1;
        tick();
        check_all("run.halt_hold", 3'b000, 1'b1, 1'b0, 8'd3);
        check("run.halt_inst", {28'd0, bus.inst}, 32'd4);

        rst      = 1'b1;
        bus.run  = 1'b0;
        bus.step = 1'b0;
        tick();
        rst = 1'b0;
        check_all("rst2", 3'b000, 1'b0, 1'b0, 8'd0);

        // Single step of LDA 0x53 with extra step pulses mid-instruction
        bus.rom_data = 8'h53;
        bus.step     = 1'b1;
        tick();
        bus.step = 1'b0;
        check_all("step.f", 3'b001, 1'b0, 1'b0, 8'd0);
        bus.step = 1'b1;
        tick();
        check_all("step.e1", 3'b010, 1'b0, 1'b0, 8'd0);
        check("step.inst", {28'd0, bus.inst}, 32'd5);
        check("step.op", {28'd0, bus.operand}, 32'd3);
        tick();
        check_all("step.e2", 3'b100, 1'b0, 1'b1, 8'd0);
        bus.step = 1'b0;
        tick();
        check_all("step.idle", 3'b000, 1'b0, 1'b0, 8'd1);
        tick();
        check_all("step.idle2", 3'b000, 1'b0, 1'b0, 8'd1);

        // Run dropped during EXEC1 of ADD 0x2A
        bus.rom_data = 8'h2A;
        bus.run      = 1'b1;
        tick();
        check_all("drop.f", 3'b001, 1'b0, 1'b0, 8'd1);
        tick();
        bus.run = 1'b0;
        check_all("drop.e1", 3'b010, 1'b0, 1'b0, 8'd1);
        tick();
        check_all("drop.e2", 3'b100, 1'b0, 1'b1, 8'd1);
        tick();
        check_all("drop.idle", 3'b000, 1'b0, 1'b0, 8'd2);

        // Reset during EXEC2 of the first LDA after reset
        rst = 1'b1;
        tick();
        rst          = 1'b0;
        bus.rom_data = 8'h53;
        bus.step     = 1'b1;
        tick();
        bus.step = 1'b0;
        tick();
        tick();
        check_all("mid.e2", 3'b100, 1'b0, 1'b1, 8'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_all("mid.rst", 3'b000, 1'b0, 1'b0, 8'd0);
        tick();
        check_all("mid.idle", 3'b000, 1'b0, 1'b0, 8'd0);

        // 256 one-exec ARM instructions wrap the counter
        bus.run = 1'b1;
        for (int i = 0; i < 256; i++) begin
            bus.rom_data = 8'h80 | 8'(i & 15);
            tick();
            check("wrap.fetch", {29'd0, bus.state}, 32'd1);
            check("wrap.cnt", {24'd0, bus.instr_count}, 32'(i));
            tick();
            check("wrap.retire", {31'd0, bus.retire}, 32'd1);
        end
        check("wrap.inst", {28'd0, bus.inst}, 32'd8);
        check("wrap.op", {28'd0, bus.operand}, 32'd15);
        bus.run = 1'b0;
        tick();
        check_all("wrap.end", 3'b000, 1'b0, 1'b0, 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
